ex_mem_stage_reg: RTL and testbench

- Parametrised EX/MEM pipeline register for the segmented processor.
- Sits between the Execute ALU/branch-adder logic and the Memory stage.
- Carries ALU result, zero flag, store data, destination register index, branch target and control bits.
- Generalises the fixed 32-bit latch with valid/ready handshake, 2-entry skid buffer, stall back-pressure, flush (bubble) and a stage-active flag.

---
 rtl/ex_mem_stage_reg.sv | 172 +++++++++++++++++
 tb/tb_ex_mem_stage_reg.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline register: valid/ready handshake with a 2-entry skid buffer, flush and bubble masking.
// Optional PERF_CNT_EN macro adds saturating stall/bubble cycle counters.
module ex_mem_stage_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned CTRL_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    input  logic [DATA_W-1:0] store_data,
    input  logic [REG_W-1:0]  dest_reg,
    input  logic [DATA_W-1:0] branch_tgt,
    input  logic [CTRL_W-1:0] ctrl_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_out_q,
    output logic              alu_zero_q,
    output logic [DATA_W-1:0] store_data_q,
    output logic [REG_W-1:0]  dest_reg_q,
    output logic [DATA_W-1:0] branch_tgt_q,
    output logic [CTRL_W-1:0] ctrl_q,
    output logic              stage_active
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt
`endif
);

    typedef struct packed {
        logic [DATA_W-1:0] alu;
        logic              zero;
        logic [DATA_W-1:0] store;
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] tgt;
        logic [CTRL_W-1:0] ctrl;
    } beat_t;

    // Encoding is {main valid, skid valid}.
    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StOne   = 2'b10,
        StFull  = 2'b11
    } state_e;

    state_e state_q, state_d;
    beat_t  m_q, m_d;
    beat_t  s_q, s_d;
    beat_t  in_beat;

    logic m_valid;
    logic s_valid;
    logic accept;
    logic handoff;

    always_comb begin
        in_beat = '{
            alu:   alu_out,
            zero:  alu_zero,
            store: store_data,
            dest:  dest_reg,
            tgt:   branch_tgt,
            ctrl:  ctrl_in
        };
        m_valid  = (state_q == StOne) || (state_q == StFull);
        s_valid  = (state_q == StFull);
        // in_ready depends only on the skid flop, so out_ready never reaches it combinationally.
        in_ready = !s_valid;
        accept   = in_valid && in_ready;
        handoff  = m_valid && out_ready;
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        if (flush) begin
            // Data registers keep their contents; only the valid state is killed.
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        m_d     = in_beat;
                        state_d = StOne;
                    end
                end
                StOne: begin
                    if (accept && handoff) begin
                        m_d = in_beat;
                    end else if (accept) begin
                        s_d     = in_beat;
                        state_d = StFull;
                    end else if (handoff) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (handoff) begin
                        m_d     = s_q;
                        state_d = StOne;
                    end
                end
                default: begin
                    state_d = StEmpty;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StEmpty;
            m_q     <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            s_q     <= s_d;
        end
    end

    always_comb begin
        out_valid    = m_valid;
        stage_active = m_valid;
        alu_out_q    = m_q.alu;
        alu_zero_q   = m_q.zero;
        store_data_q = m_q.store;
        dest_reg_q   = m_q.dest;
        branch_tgt_q = m_q.tgt;
        ctrl_q       = m_valid ? m_q.ctrl : '0;
    end

`ifdef PERF_CNT_EN
    logic        started_q, started_d;
    logic [31:0] stall_q, stall_d;
    logic [31:0] bubble_q, bubble_d;

    always_comb begin
        started_d = started_q || (accept && !flush);
        stall_d   = stall_q;
        bubble_d  = bubble_q;
        if (m_valid && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
        if (started_q && !m_valid && (bubble_q != 32'hFFFF_FFFF)) begin
            bubble_d = bubble_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            started_q <= 1'b0;
            stall_q   <= '0;
            bubble_q  <= '0;
        end else begin
            started_q <= started_d;
            stall_q   <= stall_d;
            bubble_q  <= bubble_d;
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Testbench for ex_mem_stage_reg: directed vector table, multi-cycle corner sequences and
// randomized traffic checked against a queue-based model of the two-entry buffer.
module tb_ex_mem_stage_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic [31:0] store_data;
    logic [4:0]  dest_reg;
    logic [31:0] branch_tgt;
    logic [3:0]  ctrl_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_out_q;
    logic        alu_zero_q;
    logic [31:0] store_data_q;
    logic [4:0]  dest_reg_q;
    logic [31:0] branch_tgt_q;
    logic [3:0]  ctrl_q;
    logic        stage_active;
`ifdef PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] bubble_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_mem_stage_reg #(
        .DATA_W(32),
        .REG_W (5),
        .CTRL_W(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_out     (alu_out),
        .alu_zero    (alu_zero),
        .store_data  (store_data),
        .dest_reg    (dest_reg),
        .branch_tgt  (branch_tgt),
        .ctrl_in     (ctrl_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_out_q   (alu_out_q),
        .alu_zero_q  (alu_zero_q),
        .store_data_q(store_data_q),
        .dest_reg_q  (dest_reg_q),
        .branch_tgt_q(branch_tgt_q),
        .ctrl_q      (ctrl_q),
        .stage_active(stage_active)
`ifdef PERF_CNT_EN
        ,
        .stall_cnt   (stall_cnt),
        .bubble_cnt  (bubble_cnt)
`endif
    );

    typedef struct {
        logic [31:0] alu;
        logic        zero;
        logic [31:0] store;
        logic [4:0]  dest;
        logic [31:0] tgt;
        logic [3:0]  ctrl;
    } tb_beat_t;

    typedef struct {
        logic        iv;
        logic        ordy;
        logic        fl;
        logic [31:0] alu;
        logic [3:0]  ctrl;
        logic        e_ov;
        logic        e_ir;
        logic [31:0] e_alu;
        logic [3:0]  e_ctrl;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Payload fields other than alu/ctrl derived from alu so each beat is distinct.
    task automatic drive_simple(input logic iv, input logic [31:0] alu, input logic [3:0] ctrl);
        in_valid   = iv;
        alu_out    = alu;
        alu_zero   = (alu == 32'd0);
        store_data = alu ^ 32'hFFFF_0000;
        dest_reg   = alu[4:0];
        branch_tgt = alu + 32'd4;
        ctrl_in    = ctrl;
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    vec_t     vecs[17];
    tb_beat_t mq[$];
    tb_beat_t last;
    tb_beat_t nb;

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive_simple(1'b0, 32'd0, 4'd0);

        // Reset state.
        #2;
        reset = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_alu_q", alu_out_q, 32'd0);
        chk("rst_store_q", store_data_q, 32'd0);
        chk("rst_tgt_q", branch_tgt_q, 32'd0);
        chk("rst_ctrl_q", {28'd0, ctrl_q}, 32'd0);
        step();
        reset = 1'b1;
        step();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_active", {31'd0, stage_active}, 32'd0);

        //            iv ordy fl alu          ctrl   ov ir e_alu        e_ctrl
        vecs[0]  = '{1, 1, 0, 32'h10,      4'h1,  1, 1, 32'h10,      4'h1};
        vecs[1]  = '{1, 1, 0, 32'h20,      4'h2,  1, 1, 32'h20,      4'h2};
        vecs[2]  = '{1, 1, 0, 32'h30,      4'h3,  1, 1, 32'h30,      4'h3};
        vecs[3]  = '{0, 1, 0, 32'h0,       4'h0,  0, 1, 32'h30,      4'h0};
        vecs[4]  = '{1, 0, 0, 32'hA,       4'h4,  1, 1, 32'hA,       4'h4};
        vecs[5]  = '{1, 0, 0, 32'hB,       4'h5,  1, 0, 32'hA,       4'h4};
        vecs[6]  = '{1, 0, 0, 32'hC,       4'h6,  1, 0, 32'hA,       4'h4};
        vecs[7]  = '{1, 1, 0, 32'hC,       4'h6,  1, 1, 32'hB,       4'h5};
        vecs[8]  = '{1, 1, 0, 32'hC,       4'h6,  1, 1, 32'hC,       4'h6};
        vecs[9]  = '{0, 1, 0, 32'h0,       4'h0,  0, 1, 32'hC,       4'h0};
        vecs[10] = '{0, 0, 0, 32'h55,      4'hA,  0, 1, 32'hC,       4'h0};
        vecs[11] = '{1, 0, 0, 32'h55,      4'hA,  1, 1, 32'h55,      4'hA};
        vecs[12] = '{1, 0, 0, 32'h66,      4'hF,  1, 0, 32'h55,      4'hA};
        vecs[13] = '{1, 0, 1, 32'hD,       4'h7,  0, 1, 32'h55,      4'h0};
        vecs[14] = '{0, 1, 0, 32'h0,       4'h0,  0, 1, 32'h55,      4'h0};
        vecs[15] = '{1, 0, 0, 32'h77,      4'h3,  1, 1, 32'h77,      4'h3};
        vecs[16] = '{0, 1, 1, 32'h0,       4'h0,  0, 1, 32'h77,      4'h0};

        for (int i = 0; i < 17; i++) begin
            drive_simple(vecs[i].iv, vecs[i].alu, vecs[i].ctrl);
            out_ready = vecs[i].ordy;
            flush     = vecs[i].fl;
            step();
            chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
            chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].e_ir});
            chk($sformatf("vec%0d_alu_q", i), alu_out_q, vecs[i].e_alu);
            chk($sformatf("vec%0d_ctrl_q", i), {28'd0, ctrl_q}, {28'd0, vecs[i].e_ctrl});
        end
        flush = 1'b0;

        // Asynchronous reset with a full buffer.
        out_ready = 1'b0;
        drive_simple(1'b1, 32'hE1, 4'h9);
        step();
        drive_simple(1'b1, 32'hE2, 4'hB);
        step();
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        drive_simple(1'b0, 32'd0, 4'd0);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_alu_q", alu_out_q, 32'd0);
        chk("async_rst_ctrl_q", {28'd0, ctrl_q}, 32'd0);
        chk("async_rst_dest_q", {27'd0, dest_reg_q}, 32'd0);
        step();
        reset = 1'b1;
        step();
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

`ifdef PERF_CNT_EN
        chk("perf_rst_stall", stall_cnt, 32'd0);
        chk("perf_rst_bubble", bubble_cnt, 32'd0);
        drive_simple(1'b1, 32'h100, 4'h1);
        out_ready = 1'b0;
        step();
        drive_simple(1'b0, 32'd0, 4'd0);
        for (int i = 0; i < 5; i++) step();
        // Handoff plus a new beat: neither a stall nor a bubble.
        drive_simple(1'b1, 32'h101, 4'h2);
        out_ready = 1'b1;
        step();
        drive_simple(1'b0, 32'd0, 4'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("perf_flush_stall", stall_cnt, 32'd5);
        chk("perf_flush_bubble", bubble_cnt, 32'd0);
        for (int i = 0; i < 3; i++) step();
        chk("perf_stall", stall_cnt, 32'd5);
        chk("perf_bubble", bubble_cnt, 32'd3);
`endif

        // Randomized traffic against the queue model.
        drive_simple(1'b0, 32'd0, 4'd0);
        out_ready = 1'b0;
        do_reset();
        mq.delete();
        last = '{32'd0, 1'b0, 32'd0, 5'd0, 32'd0, 4'd0};
        for (int c = 0; c < 2000; c++) begin
            nb.alu    = $urandom;
            nb.zero   = 1'($urandom);
            nb.store  = $urandom;
            nb.dest   = 5'($urandom);
            nb.tgt    = $urandom;
            nb.ctrl   = 4'($urandom);
            in_valid   = 1'($urandom);
            out_ready  = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 15) == 0);
            alu_out    = nb.alu;
            alu_zero   = nb.zero;
            store_data = nb.store;
            dest_reg   = nb.dest;
            branch_tgt = nb.tgt;
            ctrl_in    = nb.ctrl;
            if (flush) begin
                mq.delete();
            end else begin
                logic can_take;
                can_take = (mq.size() < 2);
                if (mq.size() > 0 && out_ready) void'(mq.pop_front());
                if (in_valid && can_take) mq.push_back(nb);
            end
            if (mq.size() > 0) last = mq[0];
            step();
            chk("rnd_out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
            chk("rnd_in_ready", {31'd0, in_ready}, {31'd0, mq.size() < 2});
            chk("rnd_active", {31'd0, stage_active}, {31'd0, mq.size() > 0});
            chk("rnd_alu_q", alu_out_q, last.alu);
            chk("rnd_zero_q", {31'd0, alu_zero_q}, {31'd0, last.zero});
            chk("rnd_store_q", store_data_q, last.store);
            chk("rnd_dest_q", {27'd0, dest_reg_q}, {27'd0, last.dest});
            chk("rnd_tgt_q", branch_tgt_q, last.tgt);
            chk("rnd_ctrl_q", {28'd0, ctrl_q}, {28'd0, (mq.size() > 0) ? last.ctrl : 4'd0});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
